uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; DIV = round(CLK_HZ/BAUD), 434 at defaults, SHALL be ≥2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 din  input  8  byte to transmit; sampled only at acceptance.
REQ-006 din_rdy  input  1  level request, "din valid, please send".
REQ-007 txd  output  1  serial line; idle high; 8N1 frame, LSB first.
REQ-008 tx_rdy  output  1  high = idle and able to accept a byte; low = busy.

Function
REQ-009 Baud generator: free-running counter 0..DIV-1; bclk is a 1-clk pulse when count = DIV-1, then the counter wraps to 0; bclk period is exactly DIV clks.
REQ-010 bclk is internal and never synchronised to frame start; the counter runs regardless of tx state.
REQ-011 TX FSM states: IDLE, WAIT, START, DATA, STOP.
REQ-012 IDLE: tx_rdy=1, txd=1; on a clk edge with din_rdy=1, latch din into a shift register, set tx_rdy=0, go to WAIT.
REQ-013 WAIT: txd=1; on the next bclk, drive txd=0 and go to START.
REQ-014 START: hold txd=0; on the next bclk, drive txd=shift[0] and go to DATA with bit index 0.
REQ-015 DATA: on each bclk, advance the bit index and drive the next bit, LSB first. After the bclk ending bit 7, drive txd=1 and go to STOP.
REQ-016 STOP: hold txd=1; on the next bclk, set tx_rdy=1 and go to IDLE.
REQ-017 Each frame bit (start, 8 data, stop) SHALL last exactly DIV clks. The start bit begins 1..DIV clks after acceptance.
REQ-018 din and din_rdy changes while tx_rdy=0 SHALL be ignored; the latched byte is never corrupted mid-frame.
REQ-019 din_rdy held high at a frame's end: the next byte is accepted on the first clk edge in IDLE (≥1 clk after tx_rdy rises). Back-to-back frames result, each with ≥1 idle bit-time gap.
REQ-020 din_rdy=0 in IDLE: remain in IDLE with txd=1 indefinitely.
REQ-021 txd and tx_rdy SHALL be registered outputs, glitch-free.

Reset
REQ-022 rst=1 immediately forces: baud counter=0, bclk=0, FSM=IDLE, bit index=0, shift register=0, txd=1, tx_rdy=1.
REQ-023 rst asserted mid-frame aborts the frame, with txd=1 at once. After release, operation resumes from IDLE; no partial frame is resumed.
REQ-024 After rst deasserts, the first bclk occurs exactly DIV clks later.

Structure
REQ-025 Shared package holds the FSM state enum (IDLE, WAIT, START, DATA, STOP) and the frame constants DATA_BITS=8, STOP_BITS=1.
REQ-026 The baud generator SHALL be a separate sub-module baud_gen (ports clk, rst, bclk; parameters CLK_HZ, BAUD), instantiated inside uart_tx. The tx FSM stays in uart_tx.

Verification
REQ-027 Reset: rst=1 for 100 ns -> txd=1 and tx_rdy=1 during and after reset; no bclk for DIV clks after release.
REQ-028 Single byte 0x75 (din_rdy pulsed at a bclk) -> txd sequence 0,1,0,1,0,1,1,1,0,1, each bit 434 clks (8.68 µs at 50 MHz); tx_rdy low from acceptance until after the stop bit.
REQ-029 Busy rejection: during the 0x75 frame, apply din=0x01, din_rdy=1 at a later bclk -> 0x75 frame unaffected. Dropping din_rdy on the tx_rdy rising edge -> 0x01 is not sent.
REQ-030 Back-to-back: din_rdy held high, din=0x01 -> repeated frames 0,1,0,0,0,0,0,0,0,1, each separated by ≥1 idle-high bit time; tx_rdy pulses high between frames.
REQ-031 Mid-frame reset: assert rst during data bit 3 -> txd=1 and tx_rdy=1 immediately. After release, a new byte 0xA5 transmits correctly as 0,1,0,1,0,0,1,0,1,1.
REQ-032 Baud timing: measure 100 consecutive bclk pulses -> spacing exactly DIV clks, each pulse 1 clk wide.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
// Shared definitions for the UART transmitter: the TX FSM state encoding,
// the 8N1 frame constants and the baud divisor helper.
`timescale 1ns/1ps
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int IDX_W     = $clog2(DATA_BITS);

  // Rounded divisor: round(clk_hz / baud).
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// baud_gen
// Free-running bit-rate tick generator. The counter runs 0..DIV-1 and never
// resynchronises to frame start.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bclk - one-clock-wide tick, period exactly DIV clocks
`timescale 1ns/1ps
module baud_gen
  import uart_tx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic clk,
  input  logic rst,
  output logic bclk
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;

  // The tick is registered off the terminal count, so it is high in the cycle
  // after the wrap; the first tick after reset lands exactly DIV clocks later.
  always_comb begin
    bclk_d = (cnt_q == CNT_MAX);
    cnt_d  = bclk_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk = bclk_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// 8N1 UART transmitter, LSB first, with an internal free-running baud tick.
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   din     - byte to send, latched only at acceptance
//   din_rdy - level request to send din
//   txd     - serial line, idle high (registered)
//   tx_rdy  - high when idle and able to accept a byte (registered)
//
// state | meaning
// IDLE  | line high, tx_rdy high, accept byte when din_rdy
// WAIT  | byte latched, line high until next baud tick
// START | start bit (low) on the line
// DATA  | data bit bit_idx_q on the line
// STOP  | stop bit (high) on the line
`timescale 1ns/1ps
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_rdy,
  output logic                 txd,
  output logic                 tx_rdy
);

  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  logic                 bclk;
  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [IDX_W-1:0]     next_idx;
  logic                 txd_q;
  logic                 tx_rdy_q;

  baud_gen #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .bclk(bclk)
  );

  assign next_idx = bit_idx_q + 1'b1;

  // The latched byte is never shifted; the index selects the bit, so the
  // stored value stays intact for the whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      tx_rdy_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q    <= 1'b1;
          tx_rdy_q <= 1'b1;
          if (din_rdy) begin
            shift_q  <= din;
            tx_rdy_q <= 1'b0;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (bclk) begin
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bclk) begin
            txd_q     <= shift_q[0];
            bit_idx_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bclk) begin
            if (bit_idx_q == LAST_DATA) begin
              txd_q     <= 1'b1;
              bit_idx_q <= '0;
              state_q   <= STOP;
            end else begin
              txd_q     <= shift_q[next_idx];
              bit_idx_q <= next_idx;
            end
          end
        end
        STOP: begin
          if (bclk) begin
            if (bit_idx_q == LAST_STOP) begin
              tx_rdy_q  <= 1'b1;
              bit_idx_q <= '0;
              state_q   <= IDLE;
            end else begin
              bit_idx_q <= next_idx;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd    = txd_q;
  assign tx_rdy = tx_rdy_q;

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 115200;
  localparam int DIV    = 434;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_rdy;
  logic       txd;
  logic       tx_rdy;

  int vecs = 0;
  int errs = 0;
  logic exp_q[$];

  always #10 clk = ~clk;

  uart_tx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .din_rdy(din_rdy),
    .txd    (txd),
    .tx_rdy (tx_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic wait_bclk();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dut.bclk !== 1'b1 && n < 2 * DIV);
    chk("bclk_found", {31'd0, dut.bclk}, 32'd1);
  endtask

  // Returns the number of negedges until txd is first seen low.
  task automatic wait_start(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txd !== 1'b0 && n <= 2 * DIV + 4);
    chk({tag, "_start_seen"}, {31'd0, txd}, 32'd0);
  endtask

  // Entered at the first negedge of the start bit. Each bit window is DIV
  // samples; the line must hold the scoreboard value for the whole window.
  task automatic check_frame(input string tag, input int inj_bit);
    logic first;
    logic stable;
    logic expb;
    for (int b = 0; b < 10; b++) begin
      if (b == inj_bit) begin
        din     = 8'h01;
        din_rdy = 1'b1;
      end
      expb   = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      first  = txd;
      stable = 1'b1;
      chk($sformatf("%s_bit%0d", tag, b), {31'd0, first}, {31'd0, expb});
      chk($sformatf("%s_busy%0d", tag, b), {31'd0, tx_rdy}, 32'd0);
      for (int k = 1; k < DIV; k++) begin
        @(negedge clk);
        if (txd !== first) stable = 1'b0;
      end
      chk($sformatf("%s_len%0d", tag, b), {31'd0, stable}, 32'd1);
      if (b < 9) @(negedge clk);
    end
    @(negedge clk);
    chk({tag, "_rdy_after_stop"}, {31'd0, tx_rdy}, 32'd1);
    chk({tag, "_idle_line"}, {31'd0, txd}, 32'd1);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    logic ok = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_rdy !== 1'b1) ok = 1'b0;
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1_900_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int first;

    rst     = 1'b1;
    din_rdy = 1'b0;
    din     = 8'h00;

    // Reset held for 100 ns.
    repeat (5) begin
      @(negedge clk);
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_rdy", {31'd0, tx_rdy}, 32'd1);
    end
    rst = 1'b0;

    first = 0;
    for (int k = 1; k <= DIV + 2; k++) begin
      @(negedge clk);
      if (dut.bclk === 1'b1 && first == 0) first = k;
    end
    chk("first_bclk_after_rst", first, DIV);
    chk("post_rst_txd", {31'd0, txd}, 32'd1);
    chk("post_rst_rdy", {31'd0, tx_rdy}, 32'd1);

    // Single byte 0x75 pulsed at a bclk, with a busy-time request injected.
    wait_bclk();
    din     = 8'h75;
    din_rdy = 1'b1;
    push_frame(8'h75);
    @(negedge clk);
    din_rdy = 1'b0;
    chk("f75_accept", {31'd0, tx_rdy}, 32'd0);
    wait_start("f75", n);
    chk("f75_latency", {31'd0, (n >= 1 && n <= DIV)}, 32'd1);
    check_frame("f75", 3);
    din_rdy = 1'b0;
    check_idle("no_0x01_sent", 2 * DIV);

    // Back-to-back frames with din_rdy held high.
    din     = 8'h01;
    din_rdy = 1'b1;
    push_frame(8'h01);
    push_frame(8'h01);
    @(negedge clk);
    chk("b2b_accept", {31'd0, tx_rdy}, 32'd0);
    wait_start("b2b1", n);
    chk("b2b1_latency", {31'd0, (n >= 1 && n <= DIV)}, 32'd1);
    check_frame("b2b1", -1);
    @(negedge clk);
    chk("b2b_rdy_pulse_end", {31'd0, tx_rdy}, 32'd0);
    wait_start("b2b2", n);
    chk("b2b_gap", {31'd0, (n + 1 >= DIV)}, 32'd1);
    check_frame("b2b2", -1);
    din_rdy = 1'b0;
    check_idle("b2b_stop", DIV);

    // Mid-frame reset during data bit 3 of an all-zero byte.
    din     = 8'h00;
    din_rdy = 1'b1;
    @(negedge clk);
    din_rdy = 1'b0;
    wait_start("abort", n);
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    chk("pre_abort_txd", {31'd0, txd}, 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_txd", {31'd0, txd}, 32'd1);
    chk("abort_rdy", {31'd0, tx_rdy}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("no_partial_frame", 2 * DIV);

    din     = 8'hA5;
    din_rdy = 1'b1;
    push_frame(8'hA5);
    @(negedge clk);
    din_rdy = 1'b0;
    chk("fA5_accept", {31'd0, tx_rdy}, 32'd0);
    wait_start("fA5", n);
    chk("fA5_latency", {31'd0, (n >= 1 && n <= DIV)}, 32'd1);
    check_frame("fA5", -1);
    chk("scoreboard_empty", exp_q.size(), 0);

    // 100 consecutive baud ticks: width and spacing.
    wait_bclk();
    for (int p = 0; p < 100; p++) begin
      n = 1;
      @(negedge clk);
      chk("bclk_width", {31'd0, dut.bclk}, 32'd0);
      do begin
        @(negedge clk);
        n++;
      end while (dut.bclk !== 1'b1 && n < 2 * DIV);
      chk("bclk_period", n, DIV);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
